servant_ram_arb: RTL and testbench
==================================

Name: servant_ram_arb

Overview:
- Two-master, one-slave Wishbone arbiter in front of servant_ram.
- Shares the single RAM port between the servile CPU memory bus (master 0) and a second requester (master 1), e.g. a DMA engine or debug/program loader.
- Round-robin grant per transaction, registered grant, and a watchdog that terminates a hung slave access.
- Follows the servant bus convention: cyc doubles as strobe, master holds cyc until ack, ack lasts one cycle.

Parameters:
AW, 32, address width of both master buses and the slave bus.
TIMEOUT, 15, cycles in a grant state without slave ack before forced termination; 0 disables the watchdog.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset, synchronous, active-low.
i_wb_m0_adr  in  AW  master 0 address.
i_wb_m0_dat  in  32  master 0 write data.
i_wb_m0_sel  in  4  master 0 byte select.
i_wb_m0_we  in  1  master 0 write enable.
i_wb_m0_cyc  in  1  master 0 request.
o_wb_m0_rdt  out  32  master 0 read data.
o_wb_m0_ack  out  1  master 0 ack.
i_wb_m1_adr, i_wb_m1_dat, i_wb_m1_sel, i_wb_m1_we, i_wb_m1_cyc, o_wb_m1_rdt, o_wb_m1_ack: same as master 0, for master 1.
o_wb_s_adr  out  AW  slave address.
o_wb_s_dat  out  32  slave write data.
o_wb_s_sel  out  4  slave byte select.
o_wb_s_we  out  1  slave write enable.
o_wb_s_cyc  out  1  slave request.
i_wb_s_rdt  in  32  slave read data.
i_wb_s_ack  in  1  slave ack.
o_grant  out  2  00 idle, 01 master 0 owns, 10 master 1 owns.
o_timeout  out  1  sticky watchdog-fired flag.

Behaviour:
- Reset (i_rst_n low at posedge): state IDLE, last-served = 1 (master 0 wins the first tie), watchdog count 0, o_timeout 0.
  - Outputs while in reset or IDLE: o_grant 00, o_wb_s_cyc 0, both acks 0, both rdt 0.
  - Reset mid-transaction aborts it: no ack is issued.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - Single cyc high: move to that master's GNTx.
  - Both high: grant the master not equal to last-served.
  - Neither high: stay.
  - Grant is registered, so the slave sees cyc one cycle after the request is first seen.
- GNTx:
  - Slave adr/dat/sel/we are combinationally muxed from master x.
  - o_wb_s_cyc = i_wb_mx_cyc & ~term, where term is the watchdog-firing cycle.
  - o_wb_mx_ack = i_wb_s_ack | term. o_wb_mx_rdt = term ? 0 : i_wb_s_rdt.
  - The other master's ack and rdt stay 0.
- Exit from GNTx (to IDLE on the next edge):
  - i_wb_s_ack: last-served = x.
  - Watchdog termination: last-served = x.
  - Master x drops cyc before ack (abort): no ack, last-served unchanged.
- Minimum latency: request at cycle 0, slave cyc at cycle 1, single-cycle RAM ack and master ack at cycle 2, IDLE at cycle 3.
  - A master still requesting in IDLE is re-arbitrated against the other; no master gets back-to-back grants while the other waits.
- Watchdog:
  - Counter cleared on entry to GNTx; increments each GNTx cycle without ack.
  - term asserts in the cycle where count == TIMEOUT-1 and i_wb_s_ack is 0; o_timeout sets on that edge and stays set until reset.
  - Ack and watchdog expiry in the same cycle: ack wins, o_timeout not set.
  - TIMEOUT = 0: term never asserts.
- Slave ack outside GNTx, or while the owner's cyc is low: ignored.
- Widths: counter is $clog2(TIMEOUT+1) bits minimum; no other arithmetic.

Test Plan:
- m0 read of adr 0x10 alone, slave acks 1 cycle after cyc with rdt 0xDEADBEEF -> o_grant=01, s_cyc at cycle 1, m0 ack and rdt 0xDEADBEEF at cycle 2, m1 ack 0, IDLE at cycle 3.
- m0 and m1 request together from reset, each re-requests after ack for 4 transactions -> grant order m0,m1,m0,m1; slave adr matches the owner each time.
- m1 write adr 0x20, dat 0x12345678, sel 0xF -> slave bus carries exactly those values with we=1 while o_grant=10.
- Slave never acks, TIMEOUT=15 -> m0 ack asserted with rdt 0 exactly 15 cycles after grant, s_cyc low that cycle, o_timeout=1 and stays set through later normal transactions until i_rst_n=0.
- m0 drops cyc 1 cycle into grant with m1 pending -> no m0 ack, IDLE, then m1 granted; i_rst_n=0 during GNT1 -> next cycle o_grant=00, acks 0, o_timeout 0.

Source files
------------

// File: rtl/servant_ram_arb.sv
// Two-master round-robin Wishbone arbiter in front of servant_ram.
// The grant is a registered FSM and a watchdog terminates slave accesses that never ack.
module servant_ram_arb #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_cyc,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [AW-1:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_cyc,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [AW-1:0] o_wb_s_adr,
  output logic [31:0]   o_wb_s_dat,
  output logic [3:0]    o_wb_s_sel,
  output logic          o_wb_s_we,
  output logic          o_wb_s_cyc,
  input  logic [31:0]   i_wb_s_rdt,
  input  logic          i_wb_s_ack,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  // State encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          own_cyc;
  logic          sel_m1;
  logic          term;
  logic          own_ack;
  logic [31:0]   own_rdt;

  assign sel_m1  = (state == GNT1);
  assign own_cyc = (state == GNT0) ? i_wb_m0_cyc :
                   (state == GNT1) ? i_wb_m1_cyc : 1'b0;
  // Watchdog only fires on a live request; an ack in the same cycle takes priority.
  assign term    = (TIMEOUT != 0) && own_cyc && (cnt == TMAX) && !i_wb_s_ack;
  assign own_ack = own_cyc && (i_wb_s_ack || term);
  assign own_rdt = term ? 32'h0 : i_wb_s_rdt;

  assign o_grant     = state;
  assign o_wb_s_adr  = sel_m1 ? i_wb_m1_adr : i_wb_m0_adr;
  assign o_wb_s_dat  = sel_m1 ? i_wb_m1_dat : i_wb_m0_dat;
  assign o_wb_s_sel  = sel_m1 ? i_wb_m1_sel : i_wb_m0_sel;
  assign o_wb_s_we   = sel_m1 ? i_wb_m1_we  : i_wb_m0_we;
  assign o_wb_s_cyc  = own_cyc && !term;
  assign o_wb_m0_ack = (state == GNT0) && own_ack;
  assign o_wb_m1_ack = (state == GNT1) && own_ack;
  assign o_wb_m0_rdt = (state == GNT0) ? own_rdt : 32'h0;
  assign o_wb_m1_rdt = (state == GNT1) ? own_rdt : 32'h0;

  // last = 1 means master 1 was served last, so master 0 wins the next tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_wb_m0_cyc && (!i_wb_m1_cyc || last))
            state <= GNT0;
          else if (i_wb_m1_cyc)
            state <= GNT1;
        end
        GNT0, GNT1: begin
          if (!own_cyc) begin
            state <= IDLE;
          end else if (i_wb_s_ack || term) begin
            state <= IDLE;
            last  <= (state == GNT1);
            if (term)
              o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_ram_arb.sv
// Directed self-checking bench for servant_ram_arb: single access, round-robin,
// write muxing, watchdog termination, abort and mid-transaction reset.
module tb_servant_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m1_we, m1_cyc;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [31:0] s_adr, s_dat, s_rdt;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_ack;
  logic [1:0]  grant;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  servant_ram_arb #(.AW(32), .TIMEOUT(15)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wb_m0_adr (m0_adr),
    .i_wb_m0_dat (m0_dat),
    .i_wb_m0_sel (m0_sel),
    .i_wb_m0_we  (m0_we),
    .i_wb_m0_cyc (m0_cyc),
    .o_wb_m0_rdt (m0_rdt),
    .o_wb_m0_ack (m0_ack),
    .i_wb_m1_adr (m1_adr),
    .i_wb_m1_dat (m1_dat),
    .i_wb_m1_sel (m1_sel),
    .i_wb_m1_we  (m1_we),
    .i_wb_m1_cyc (m1_cyc),
    .o_wb_m1_rdt (m1_rdt),
    .o_wb_m1_ack (m1_ack),
    .o_wb_s_adr  (s_adr),
    .o_wb_s_dat  (s_dat),
    .o_wb_s_sel  (s_sel),
    .o_wb_s_we   (s_we),
    .o_wb_s_cyc  (s_cyc),
    .i_wb_s_rdt  (s_rdt),
    .i_wb_s_ack  (s_ack),
    .o_grant     (grant),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic c0, input logic c1, input logic ack,
                               input logic [31:0] rdt);
    m0_cyc = c0;
    m1_cyc = c1;
    s_ack  = ack;
    s_rdt  = rdt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    m0_adr = 32'h0; m0_dat = 32'h0; m0_sel = 4'h0; m0_we = 1'b0;
    m1_adr = 32'h0; m1_dat = 32'h0; m1_sel = 4'h0; m1_we = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Reset state
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_scyc", 32'(s_cyc), 32'h0);
    checkOutput("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    checkOutput("rst_rdt0", m0_rdt, 32'h0);
    checkOutput("rst_tmo", 32'(timeout), 32'h0);

    // Single m0 read: request cycle 0, slave cyc cycle 1, ack cycle 2, idle cycle 3
    rst_n  = 1'b1;
    m0_adr = 32'h10;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_c0_grant", 32'(grant), 32'h0);
    checkOutput("t1_c0_scyc", 32'(s_cyc), 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_c1_grant", 32'(grant), 32'h1);
    checkOutput("t1_c1_scyc", 32'(s_cyc), 32'h1);
    checkOutput("t1_c1_sadr", s_adr, 32'h10);
    checkOutput("t1_c1_ack", 32'(m0_ack), 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("t1_c2_ack", 32'(m0_ack), 32'h1);
    checkOutput("t1_c2_rdt", m0_rdt, 32'hDEADBEEF);
    checkOutput("t1_c2_m1ack", 32'(m1_ack), 32'h0);
    checkOutput("t1_c2_m1rdt", m1_rdt, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_c3_grant", 32'(grant), 32'h0);
    checkOutput("t1_c3_ack", 32'(m0_ack), 32'h0);

    // Tie from reset: master 0 first, then strict alternation
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    m0_adr = 32'h100;
    m1_adr = 32'h200;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("t2_grant%0d", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("t2_sadr%0d", i), s_adr, (i % 2 == 0) ? 32'h100 : 32'h200);
      step();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(i));
      checkOutput($sformatf("t2_acks%0d", i), 32'({m1_ack, m0_ack}),
                  (i % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("t2_rdt%0d", i), (i % 2 == 0) ? m0_rdt : m1_rdt,
                  32'h1000 + 32'(i));
      step();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("t2_idle%0d", i), 32'(grant), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    // m1 write is muxed onto the slave bus unchanged
    m1_adr = 32'h20; m1_dat = 32'h12345678; m1_sel = 4'hF; m1_we = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_grant", 32'(grant), 32'h2);
    checkOutput("t3_sadr", s_adr, 32'h20);
    checkOutput("t3_sdat", s_dat, 32'h12345678);
    checkOutput("t3_ssel", 32'(s_sel), 32'hF);
    checkOutput("t3_swe", 32'(s_we), 32'h1);
    checkOutput("t3_scyc", 32'(s_cyc), 32'h1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("t3_ack", 32'({m1_ack, m0_ack}), 32'h2);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    m1_we = 1'b0;

    // Watchdog: slave never acks, termination on the 15th grant cycle
    m0_adr = 32'h40;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hAAAA5555);
    for (int n = 1; n < 15; n++) begin
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'hAAAA5555);
      checkOutput($sformatf("t4_noack%0d", n), 32'({m0_ack, s_cyc}), 32'h1);
    end
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hAAAA5555);
    checkOutput("t4_grant", 32'(grant), 32'h1);
    checkOutput("t4_ack", 32'(m0_ack), 32'h1);
    checkOutput("t4_rdt", m0_rdt, 32'h0);
    checkOutput("t4_scyc", 32'(s_cyc), 32'h0);
    checkOutput("t4_tmo_pre", 32'(timeout), 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_idle", 32'(grant), 32'h0);
    checkOutput("t4_tmo", 32'(timeout), 32'h1);
    step();
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h5);
    checkOutput("t4_norm_ack", 32'(m1_ack), 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_tmo_sticky", 32'(timeout), 32'h1);

    // m0 aborts one cycle into its grant while m1 waits; stray acks ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_grant0", 32'(grant), 32'h1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77);
    checkOutput("t5_abort_ack", 32'({m1_ack, m0_ack}), 32'h0);
    checkOutput("t5_abort_scyc", 32'(s_cyc), 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77);
    checkOutput("t5_idle", 32'(grant), 32'h0);
    checkOutput("t5_idle_ack", 32'({m1_ack, m0_ack}), 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_grant1", 32'(grant), 32'h2);
    checkOutput("t5_tmo_held", 32'(timeout), 32'h1);
    rst_n = 1'b0;
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_rst_grant", 32'(grant), 32'h0);
    checkOutput("t5_rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
    checkOutput("t5_rst_tmo", 32'(timeout), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
